dpram_port_arbiter: RTL and testbench

- Round-robin arbiter that shares the two ports of the single-clock 256x16 true dual-port RAM between NREQ requesters.
- Grants up to two requests per cycle, one on RAM port A and one on RAM port B.
- Prevents same-address port collisions.
- Returns read data to the owning requester with a fixed 1-cycle latency.
- Sits between the compute/DMA clients and the RAM instance; it is the only driver of the RAM ports.

---
 rtl/dpram_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_port_arbiter
//
// Shares the two ports of a single-clock true dual-port RAM (registered read
// data) between NREQ requesters. Each cycle a round-robin scan starting at
// rr_ptr picks up to two requests: the first asserted request goes to port A,
// and the next one that does not collide with it goes to port B. Two accesses
// collide when they target the same address and at least one of them writes.
// Read data comes back one cycle after the grant, steered to the owning
// requester.
//
// Ports
//   clk        : system clock, all state on the rising edge
//   rst        : synchronous active-high reset
//   req        : per-requester request, held until granted
//   req_we     : per-requester write enable (1 = write, 0 = read)
//   req_addr   : per-requester address, slice i = [i*AW +: AW]
//   req_wdata  : per-requester write data, slice i = [i*DW +: DW]
//   gnt        : grant, at most two bits set, same cycle the request is issued
//   rd_valid   : read data valid for requester i (one cycle after its grant)
//   rd_data    : read data, slice i meaningful when rd_valid[i], else 0
//   ram_*_a/b  : RAM port A / port B address, write data, write enable
//   ram_q_a/b  : RAM port A / port B registered read data
// -----------------------------------------------------------------------------
module dpram_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rd_valid,
  output logic [NREQ*DW-1:0] rd_data,
  output logic [AW-1:0]      ram_addr_a,
  output logic [DW-1:0]      ram_data_a,
  output logic               ram_we_a,
  input  logic [DW-1:0]      ram_q_a,
  output logic [AW-1:0]      ram_addr_b,
  output logic [DW-1:0]      ram_data_b,
  output logic               ram_we_b,
  input  logic [DW-1:0]      ram_q_b
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Unpacked views of the flat request buses.
  logic [AW-1:0] addr_arr  [NREQ];
  logic [DW-1:0] wdata_arr [NREQ];

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_ptr_nxt;
  logic [PW-1:0] last_idx;

  logic          a_found, b_found;
  logic [PW-1:0] a_idx, b_idx;
  logic [PW:0]   scan_sum;
  logic [PW-1:0] scan_idx;

  logic [NREQ-1:0] b_onehot;
  // Per requester: 1 when its pending read was issued on port B.
  logic [NREQ-1:0] owner_b;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*AW +: AW];
    assign wdata_arr[g] = req_wdata[g*DW +: DW];
  end

  // Round-robin scan. scan_sum is one bit wider than the pointer so that
  // rr_ptr + k can be wrapped modulo NREQ for any NREQ, not only powers of 2.
  always_comb begin : arbitrate
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves a value held and no latch is inferred.
    a_found  = 1'b0;
    b_found  = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NREQ)) begin
        scan_sum = scan_sum - (PW+1)'(NREQ);
      end
      scan_idx = scan_sum[PW-1:0];
      if (req[scan_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = scan_idx;
        end else if (!b_found &&
                     !((addr_arr[scan_idx] == addr_arr[a_idx]) &&
                       (req_we[a_idx] || req_we[scan_idx]))) begin
          // Same-address read/read is allowed on both ports; anything
          // involving a write to that address waits for a later cycle.
          b_found = 1'b1;
          b_idx   = scan_idx;
        end
      end
    end
  end

  // Pointer moves just past the last requester granted in scan order.
  always_comb begin : next_ptr
    last_idx   = b_found ? b_idx : a_idx;
    rr_ptr_nxt = (last_idx == PW'(NREQ-1)) ? '0 : last_idx + PW'(1);
  end

  // Grant and RAM port drive; everything is held quiet while rst is high.
  always_comb begin : drive
    gnt        = '0;
    b_onehot   = '0;
    ram_addr_a = '0;
    ram_data_a = '0;
    ram_we_a   = 1'b0;
    ram_addr_b = '0;
    ram_data_b = '0;
    ram_we_b   = 1'b0;
    if (!rst) begin
      if (a_found) begin
        gnt[a_idx] = 1'b1;
        ram_addr_a = addr_arr[a_idx];
        ram_data_a = wdata_arr[a_idx];
        ram_we_a   = req_we[a_idx];
      end
      if (b_found) begin
        gnt[b_idx]      = 1'b1;
        b_onehot[b_idx] = 1'b1;
        ram_addr_b      = addr_arr[b_idx];
        ram_data_b      = wdata_arr[b_idx];
        ram_we_b        = req_we[b_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      rr_ptr   <= '0;
      rd_valid <= '0;
      owner_b  <= '0;
    end else begin
      if (a_found) begin
        rr_ptr <= rr_ptr_nxt;
      end
      rd_valid <= gnt & ~req_we;
      owner_b  <= b_onehot;
    end
  end

  // The RAM registers its read data on the same edge that registers
  // rd_valid/owner_b, so the return path is a plain mux with no extra flops.
  for (genvar g = 0; g < NREQ; g++) begin : g_rdata
    assign rd_data[g*DW +: DW] = rd_valid[g] ? (owner_b[g] ? ram_q_b : ram_q_a)
                                             : '0;
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpram_port_arbiter
//
// Drives dpram_port_arbiter attached to a behavioural 256x16 dual-port RAM.
// A reference model (requester list in scan order, array memory) predicts the
// grants, RAM port drive and read returns. Directed scenarios are followed by
// randomized traffic on a small address pool so collisions are frequent.
// -----------------------------------------------------------------------------
module tb_dpram_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int PORTW = 1 + AW + DW;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rd_valid;
  logic [NREQ*DW-1:0] rd_data;
  logic [AW-1:0]      ram_addr_a, ram_addr_b;
  logic [DW-1:0]      ram_data_a, ram_data_b;
  logic               ram_we_a, ram_we_b;
  logic [DW-1:0]      ram_q_a, ram_q_b;

  always #5 clk = ~clk;

  dpram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .ram_addr_a (ram_addr_a),
    .ram_data_a (ram_data_a),
    .ram_we_a   (ram_we_a),
    .ram_q_a    (ram_q_a),
    .ram_addr_b (ram_addr_b),
    .ram_data_b (ram_data_b),
    .ram_we_b   (ram_we_b),
    .ram_q_b    (ram_q_b)
  );

  // Behavioural RAM; a load port fills it at start-up.
  logic [DW-1:0] ram [256];
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;

  always @(posedge clk) begin
    if (load_en)  ram[load_addr]  <= load_data;
    if (ram_we_a) ram[ram_addr_a] <= ram_data_a;
    if (ram_we_b) ram[ram_addr_b] <= ram_data_b;
    ram_q_a <= ram[ram_addr_a];
    ram_q_b <= ram[ram_addr_b];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0]      m_mem [256];
  int                 m_ptr = 0;
  logic [NREQ-1:0]    m_rv  = '0;
  logic [NREQ*DW-1:0] m_rd  = '0;
  int                 e_a, e_b;
  logic [NREQ-1:0]    e_gnt;
  logic [PORTW-1:0]   e_port_a, e_port_b;

  function automatic logic [AW-1:0] f_addr(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] f_wd(input int i);
    return req_wdata[i*DW +: DW];
  endfunction

  // Predicts this cycle's grants from the current requests.
  task automatic model_eval();
    int order[$];
    int a, b;
    a = -1;
    b = -1;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (req[i]) order.push_back(i);
      end
      if (order.size() > 0) a = order[0];
      for (int j = 1; j < order.size(); j++) begin
        if (b < 0 && !(f_addr(order[j]) == f_addr(a) &&
                       (req_we[a] || req_we[order[j]])))
          b = order[j];
      end
    end
    e_a      = a;
    e_b      = b;
    e_gnt    = '0;
    e_port_a = '0;
    e_port_b = '0;
    if (a >= 0) begin
      e_gnt[a] = 1'b1;
      e_port_a = {req_we[a], f_addr(a), f_wd(a)};
    end
    if (b >= 0) begin
      e_gnt[b] = 1'b1;
      e_port_b = {req_we[b], f_addr(b), f_wd(b)};
    end
  endtask

  // Advances the model across the coming edge, then waits for it.
  task automatic tick();
    logic [NREQ-1:0]    nrv;
    logic [NREQ*DW-1:0] nrd;
    nrv = '0;
    nrd = '0;
    if (rst) begin
      m_ptr = 0;
    end else if (e_a >= 0) begin
      if (!req_we[e_a]) begin
        nrv[e_a] = 1'b1;
        nrd[e_a*DW +: DW] = m_mem[f_addr(e_a)];
      end
      if (e_b >= 0 && !req_we[e_b]) begin
        nrv[e_b] = 1'b1;
        nrd[e_b*DW +: DW] = m_mem[f_addr(e_b)];
      end
      if (req_we[e_a]) m_mem[f_addr(e_a)] = f_wd(e_a);
      if (e_b >= 0 && req_we[e_b]) m_mem[f_addr(e_b)] = f_wd(e_b);
      m_ptr = (((e_b >= 0) ? e_b : e_a) + 1) % NREQ;
    end
    m_rv = nrv;
    m_rd = nrd;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic clear_reqs();
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i]                = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic drop_granted();
    req = req & ~e_gnt;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    clear_reqs();
    repeat (n) begin
      settle();
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic preload();
    rst     = 1'b1;
    load_en = 1'b1;
    clear_reqs();
    for (int a = 0; a < 256; a++) begin
      load_addr = AW'(a);
      load_data = (a == 'h7F) ? 16'h1234 : DW'($urandom);
      m_mem[a]  = load_data;
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    set_req(0, 1'b0, 8'h10, 16'h0);
    set_req(1, 1'b0, 8'h20, 16'h0);
    set_req(2, 1'b0, 8'h30, 16'h0);
    set_req(3, 1'b0, 8'h40, 16'h0);
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (gnt !== '0) begin
        errors++;
        $display("FAIL reset_gnt: got %b expected 0000", gnt);
      end
      checks++;
      if ({ram_we_a, ram_addr_a, ram_data_a, ram_we_b, ram_addr_b, ram_data_b} !== '0) begin
        errors++;
        $display("FAIL reset_ram_ports: got we_a=%b we_b=%b addr_a=%h addr_b=%h expected all 0",
                 ram_we_a, ram_we_b, ram_addr_a, ram_addr_b);
      end
      checks++;
      if (rd_valid !== '0) begin
        errors++;
        $display("FAIL reset_rd_valid: got %b expected 0000", rd_valid);
      end
      tick();
    end
    rst = 1'b0;
    settle();
    checks++;
    if (gnt !== 4'b0011) begin
      errors++;
      $display("FAIL release_gnt: got %b expected 0011", gnt);
    end
    checks++;
    if (gnt !== e_gnt) begin
      errors++;
      $display("FAIL release_gnt_model: got %b expected %b", gnt, e_gnt);
    end
    tick();
  endtask

  // Requests from test_reset stay asserted: continuous distinct-address reads.
  task automatic test_round_robin();
    logic [NREQ-1:0] lit;
    for (int c = 0; c < 8; c++) begin
      settle();
      lit = (c % 2 == 0) ? 4'b1100 : 4'b0011;
      checks++;
      if (gnt !== lit || gnt !== e_gnt) begin
        errors++;
        $display("FAIL rr_gnt c=%0d: got %b expected %b", c, gnt, lit);
      end
      checks++;
      if (rd_valid !== m_rv) begin
        errors++;
        $display("FAIL rr_rd_valid c=%0d: got %b expected %b", c, rd_valid, m_rv);
      end
      checks++;
      if (rd_data !== m_rd) begin
        errors++;
        $display("FAIL rr_rd_data c=%0d: got %h expected %h", c, rd_data, m_rd);
      end
      tick();
    end
  endtask

  task automatic test_write_conflict();
    apply_reset(1);
    set_req(0, 1'b1, 8'h55, 16'hBEEF);
    set_req(1, 1'b0, 8'h55, 16'h0);
    settle();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL wc_gnt1: got %b expected 0001", gnt);
    end
    checks++;
    if ({ram_we_a, ram_addr_a, ram_data_a} !== {1'b1, 8'h55, 16'hBEEF} ||
        {ram_we_b, ram_addr_b, ram_data_b} !== '0) begin
      errors++;
      $display("FAIL wc_ports1: got a=%b/%h/%h b=%b/%h/%h expected a=1/55/beef b=0/00/0000",
               ram_we_a, ram_addr_a, ram_data_a, ram_we_b, ram_addr_b, ram_data_b);
    end
    tick();
    drop_granted();
    settle();
    checks++;
    if (gnt !== 4'b0010 || ram_addr_a !== 8'h55 || ram_we_a !== 1'b0) begin
      errors++;
      $display("FAIL wc_gnt2: got gnt=%b addr_a=%h we_a=%b expected 0010/55/0",
               gnt, ram_addr_a, ram_we_a);
    end
    tick();
    drop_granted();
    settle();
    checks++;
    if (rd_valid !== 4'b0010 || rd_data[DW +: DW] !== 16'hBEEF) begin
      errors++;
      $display("FAIL wc_readback: got valid=%b data=%h expected 0010/beef",
               rd_valid, rd_data[DW +: DW]);
    end
    checks++;
    if (rd_data !== m_rd) begin
      errors++;
      $display("FAIL wc_rd_data_model: got %h expected %h", rd_data, m_rd);
    end
    tick();
  endtask

  task automatic test_shared_read();
    apply_reset(1);
    set_req(2, 1'b0, 8'h7F, 16'h0);
    set_req(3, 1'b0, 8'h7F, 16'h0);
    settle();
    checks++;
    if (gnt !== 4'b1100 || ram_addr_a !== 8'h7F || ram_addr_b !== 8'h7F) begin
      errors++;
      $display("FAIL sr_gnt: got gnt=%b addr_a=%h addr_b=%h expected 1100/7f/7f",
               gnt, ram_addr_a, ram_addr_b);
    end
    tick();
    drop_granted();
    settle();
    checks++;
    if (rd_valid !== 4'b1100 || rd_data[2*DW +: DW] !== 16'h1234 ||
        rd_data[3*DW +: DW] !== 16'h1234) begin
      errors++;
      $display("FAIL sr_readback: got valid=%b d2=%h d3=%h expected 1100/1234/1234",
               rd_valid, rd_data[2*DW +: DW], rd_data[3*DW +: DW]);
    end
    tick();
  endtask

  task automatic test_dual_write();
    apply_reset(1);
    set_req(0, 1'b1, 8'h01, 16'hAAAA);
    set_req(3, 1'b1, 8'h02, 16'h5555);
    settle();
    checks++;
    if (gnt !== 4'b1001) begin
      errors++;
      $display("FAIL dw_gnt: got %b expected 1001", gnt);
    end
    checks++;
    if ({ram_we_a, ram_addr_a, ram_data_a} !== {1'b1, 8'h01, 16'hAAAA} ||
        {ram_we_b, ram_addr_b, ram_data_b} !== {1'b1, 8'h02, 16'h5555}) begin
      errors++;
      $display("FAIL dw_ports: got a=%b/%h/%h b=%b/%h/%h expected a=1/01/aaaa b=1/02/5555",
               ram_we_a, ram_addr_a, ram_data_a, ram_we_b, ram_addr_b, ram_data_b);
    end
    tick();
    drop_granted();
    set_req(1, 1'b0, 8'h01, 16'h0);
    set_req(2, 1'b0, 8'h02, 16'h0);
    settle();
    checks++;
    if (gnt !== 4'b0110) begin
      errors++;
      $display("FAIL dw_read_gnt: got %b expected 0110", gnt);
    end
    tick();
    drop_granted();
    settle();
    checks++;
    if (rd_valid !== 4'b0110 || rd_data[DW +: DW] !== 16'hAAAA ||
        rd_data[2*DW +: DW] !== 16'h5555) begin
      errors++;
      $display("FAIL dw_readback: got valid=%b d1=%h d2=%h expected 0110/aaaa/5555",
               rd_valid, rd_data[DW +: DW], rd_data[2*DW +: DW]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] b2b_addr [4];
    b2b_addr = '{8'h10, 8'h20, 8'h30, 8'h40};
    apply_reset(1);
    for (int c = 0; c < 5; c++) begin
      clear_reqs();
      if (c < 4) set_req(0, 1'b0, b2b_addr[c], 16'h0);
      settle();
      if (c < 4) begin
        checks++;
        if (gnt !== 4'b0001) begin
          errors++;
          $display("FAIL b2b_gnt c=%0d: got %b expected 0001", c, gnt);
        end
      end
      if (c > 0) begin
        checks++;
        if (rd_valid !== 4'b0001 || rd_data[DW-1:0] !== m_mem[b2b_addr[c-1]]) begin
          errors++;
          $display("FAIL b2b_read c=%0d: got valid=%b data=%h expected 0001/%h",
                   c, rd_valid, rd_data[DW-1:0], m_mem[b2b_addr[c-1]]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    apply_reset(1);
    set_req(1, 1'b0, 8'h20, 16'h0);
    settle();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL mid_gnt: got %b expected 0010", gnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_reqs();
    set_req(0, 1'b0, 8'h10, 16'h0);
    set_req(1, 1'b0, 8'h20, 16'h0);
    set_req(2, 1'b0, 8'h30, 16'h0);
    set_req(3, 1'b0, 8'h40, 16'h0);
    settle();
    checks++;
    if (rd_valid !== '0) begin
      errors++;
      $display("FAIL mid_rd_valid: got %b expected 0000", rd_valid);
    end
    checks++;
    if (gnt !== 4'b0011) begin
      errors++;
      $display("FAIL mid_restart_gnt: got %b expected 0011", gnt);
    end
    tick();
    clear_reqs();
    settle();
    tick();
  endtask

  task automatic test_random();
    apply_reset(1);
    for (int c = 0; c < 400; c++) begin
      settle();
      checks++;
      if (gnt !== e_gnt) begin
        errors++;
        $display("FAIL rnd_gnt c=%0d: got %b expected %b", c, gnt, e_gnt);
      end
      checks++;
      if ({ram_we_a, ram_addr_a, ram_data_a} !== e_port_a) begin
        errors++;
        $display("FAIL rnd_port_a c=%0d: got %h expected %h", c,
                 {ram_we_a, ram_addr_a, ram_data_a}, e_port_a);
      end
      checks++;
      if ({ram_we_b, ram_addr_b, ram_data_b} !== e_port_b) begin
        errors++;
        $display("FAIL rnd_port_b c=%0d: got %h expected %h", c,
                 {ram_we_b, ram_addr_b, ram_data_b}, e_port_b);
      end
      checks++;
      if (rd_valid !== m_rv) begin
        errors++;
        $display("FAIL rnd_rd_valid c=%0d: got %b expected %b", c, rd_valid, m_rv);
      end
      checks++;
      if (rd_data !== m_rd) begin
        errors++;
        $display("FAIL rnd_rd_data c=%0d: got %h expected %h", c, rd_data, m_rd);
      end
      tick();
      // Granted or idle requesters may issue something new; others hold.
      for (int i = 0; i < NREQ; i++) begin
        if (e_gnt[i] || !req[i]) begin
          if ($urandom_range(99) < 60)
            set_req(i, ($urandom_range(99) < 30), AW'($urandom_range(7)), DW'($urandom));
          else
            req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // NOTE: bench inputs are driven with blocking assignments from procedural
    // code, away from the clock edge the DUT samples on.
    preload();
    test_reset();
    test_round_robin();
    test_write_conflict();
    test_shared_read();
    test_dual_write();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
